// File: rtl/adc_stream_capture.sv
// rtl/adc_stream_capture.sv - dual-channel ADC capture into framed AXI-Stream words,
// with over-range stretching and an IDELAY reset pulse generator.
module adc_stream_capture #(
  parameter int DATA_WIDTH     = 14,
  parameter int FRAME_LEN      = 1024,
  parameter int FIFO_DEPTH     = 16,
  parameter int OR_HOLD        = 1024,
  parameter int DLY_RST_CYCLES = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] adc_data_a,
  input  logic [DATA_WIDTH-1:0] adc_data_b,
  input  logic                  adc_or_a,
  input  logic                  adc_or_b,
  input  logic                  data_en,
  input  logic                  delay_rst,
  output logic [1:0]            adc_or_state,
  output logic                  idelay_rst,
  output logic                  overflow,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam int CW  = $clog2(FRAME_LEN);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int OW  = $clog2(OR_HOLD + 1);
  localparam int DW  = $clog2(DLY_RST_CYCLES + 1);
  localparam int EXT = 16 - DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     word_q, word_d;
  logic            last_q, last_d, push_q, push_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [32:0]     mem_q [FIFO_DEPTH];
  logic            ovf_q, ovf_d, en_prev_q, en_prev_d, dly_prev_q, dly_prev_d;
  logic [OW-1:0]   or_a_cnt_q, or_a_cnt_d, or_b_cnt_q, or_b_cnt_d;
  logic [DW-1:0]   dly_cnt_q, dly_cnt_d;

  logic            cap, is_last, empty, full, pop, wr_en, drop;
  logic [32:0]     head;

  // A sample is taken whenever enabled, or mid-frame so that frames are never cut short.
  always_comb begin
    cap     = data_en | ((state_q != IDLE) && (cnt_q != '0));
    is_last = (cnt_q == LAST);
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cap) begin
      cnt_d = is_last ? '0 : cnt_q + CW'(1);
      if (data_en)      state_d = STREAM;
      else if (is_last) state_d = IDLE;
      else              state_d = DRAIN;
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    word_d = cap ? {{EXT{adc_data_b[DATA_WIDTH-1]}}, adc_data_b,
                    {EXT{adc_data_a[DATA_WIDTH-1]}}, adc_data_a} : word_q;
    push_d = cap;
    last_d = cap & is_last;
  end

  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop   = !empty && m_axis_tready;
    wr_en = push_q && (!full || pop);
    drop  = push_q && full && !pop;
    wr_d  = wr_q + PW'(wr_en);
    rd_d  = rd_q + PW'(pop);
    head  = mem_q[rd_q[AW-1:0]];
    en_prev_d  = data_en;
    dly_prev_d = delay_rst;
    ovf_d = (ovf_q & ~(data_en & ~en_prev_q)) | drop;
  end

  always_comb begin
    or_a_cnt_d = adc_or_a ? OW'(OR_HOLD) : (or_a_cnt_q != '0) ? or_a_cnt_q - OW'(1) : or_a_cnt_q;
    or_b_cnt_d = adc_or_b ? OW'(OR_HOLD) : (or_b_cnt_q != '0) ? or_b_cnt_q - OW'(1) : or_b_cnt_q;
    if (delay_rst && !dly_prev_q) dly_cnt_d = DW'(DLY_RST_CYCLES);
    else if (dly_cnt_q != '0)     dly_cnt_d = dly_cnt_q - DW'(1);
    else                          dly_cnt_d = dly_cnt_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      push_q     <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      ovf_q      <= 1'b0;
      en_prev_q  <= 1'b0;
      dly_prev_q <= 1'b0;
      or_a_cnt_q <= '0;
      or_b_cnt_q <= '0;
      dly_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      last_q     <= last_d;
      push_q     <= push_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ovf_q      <= ovf_d;
      en_prev_q  <= en_prev_d;
      dly_prev_q <= dly_prev_d;
      or_a_cnt_q <= or_a_cnt_d;
      or_b_cnt_q <= or_b_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= {last_q, word_q};
  end

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? 32'd0 : head[31:0];
  assign m_axis_tlast  = !empty && head[32];
  assign overflow      = ovf_q;
  assign adc_or_state  = {or_a_cnt_q != '0, or_b_cnt_q != '0};
  assign idelay_rst    = (dly_cnt_q != '0);

endmodule

// File: tb/tb_adc_stream_capture.sv
// tb/tb_adc_stream_capture.sv - directed self-checking bench for adc_stream_capture.
module tb_adc_stream_capture;

  logic        aclk = 1'b0;
  logic        areset;
  logic [13:0] adc_data_a, adc_data_b;
  logic        adc_or_a, adc_or_b, data_en, delay_rst;
  logic [1:0]  adc_or_state;
  logic        idelay_rst, overflow;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] got_data[$];
  logic        got_last[$];

  adc_stream_capture #(
    .DATA_WIDTH(14), .FRAME_LEN(4), .FIFO_DEPTH(16), .OR_HOLD(1024), .DLY_RST_CYCLES(8)
  ) dut (
    .aclk(aclk), .areset(areset),
    .adc_data_a(adc_data_a), .adc_data_b(adc_data_b),
    .adc_or_a(adc_or_a), .adc_or_b(adc_or_b),
    .data_en(data_en), .delay_rst(delay_rst),
    .adc_or_state(adc_or_state), .idelay_rst(idelay_rst), .overflow(overflow),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  always #5 aclk = ~aclk;

  // Handshake recorder: values seen at the falling edge are those transferred at the next rising edge.
  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      got_data.push_back(m_axis_tdata);
      got_last.push_back(m_axis_tlast);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [13:0] a, input logic [13:0] b);
    return {{2{b[13]}}, b, {2{a[13]}}, a};
  endfunction

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) tick();
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
    n_cmp++; if (m_axis_tdata !== 32'd0) begin n_err++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
    n_cmp++; if (adc_or_state !== 2'b00) begin n_err++; $display("FAIL reset_or_state got %b want 00", adc_or_state); end
    n_cmp++; if (idelay_rst !== 1'b0) begin n_err++; $display("FAIL reset_idelay got %b want 0", idelay_rst); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
    areset = 1'b0;
    tick();
  endtask

  task automatic test_capture();
    got_data.delete(); got_last.delete();
    m_axis_tready = 1'b1;
    adc_data_a = 14'h1FFF; adc_data_b = 14'h2000;
    data_en = 1'b1;
    repeat (6) tick();
    data_en = 1'b0;
    repeat (20) tick();
    n_cmp++; if (got_data.size() != 8) begin n_err++; $display("FAIL capture_count got %0d want 8", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      n_cmp++; if (got_data[i] !== 32'hE0001FFF) begin n_err++; $display("FAIL capture_data[%0d] got %h want e0001fff", i, got_data[i]); end
      n_cmp++; if (got_last[i] !== (i == 3 || i == 7)) begin n_err++; $display("FAIL capture_last[%0d] got %b want %b", i, got_last[i], (i == 3 || i == 7)); end
    end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL capture_idle_tvalid got %b want 0", m_axis_tvalid); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL capture_overflow got %b want 0", overflow); end
  endtask

  task automatic test_backpressure();
    got_data.delete(); got_last.delete();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      adc_data_a = 14'(i); adc_data_b = 14'h3FFF - 14'(i);
      data_en = 1'b1;
      tick();
    end
    data_en = 1'b0;
    repeat (3) tick();
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow got %b want 1", overflow); end
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_tvalid got %b want 1", m_axis_tvalid); end
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (m_axis_tdata !== mk(14'h0, 14'h3FFF) || m_axis_tlast !== 1'b0 || m_axis_tvalid !== 1'b1)
        begin n_err++; $display("FAIL bp_hold[%0d] got %h/%b/%b want %h/0/1", c, m_axis_tdata, m_axis_tlast, m_axis_tvalid, mk(14'h0, 14'h3FFF)); end
      tick();
    end
    m_axis_tready = 1'b1;
    repeat (24) tick();
    n_cmp++; if (got_data.size() != 16) begin n_err++; $display("FAIL bp_count got %0d want 16", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 16; i++) begin
      n_cmp++; if (got_data[i] !== mk(14'(i), 14'h3FFF - 14'(i)) || got_last[i] !== (i % 4 == 3))
        begin n_err++; $display("FAIL bp_word[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], mk(14'(i), 14'h3FFF - 14'(i)), (i % 4 == 3)); end
    end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b want 0", m_axis_tvalid); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_sticky got %b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    got_data.delete(); got_last.delete();
    for (int i = 0; i < 24; i++) begin
      adc_data_a = 14'(i); adc_data_b = 14'(i + 100);
      m_axis_tready = (i >= 17);
      data_en = 1'b1;
      tick();
      if (i == 0) begin
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fp_clear got %b want 0", overflow); end
      end
    end
    data_en = 1'b0;
    m_axis_tready = 1'b1;
    repeat (40) tick();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fp_overflow got %b want 0", overflow); end
    n_cmp++; if (got_data.size() != 24) begin n_err++; $display("FAIL fp_count got %0d want 24", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 24; i++) begin
      n_cmp++; if (got_data[i] !== mk(14'(i), 14'(i + 100)) || got_last[i] !== (i % 4 == 3))
        begin n_err++; $display("FAIL fp_word[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], mk(14'(i), 14'(i + 100)), (i % 4 == 3)); end
    end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL fp_drained got %b want 0", m_axis_tvalid); end
  endtask

  task automatic test_over_range();
    int hi_a, hi_b;
    hi_a = 0; hi_b = 0;
    adc_or_a = 1'b1;
    tick();
    adc_or_a = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      if (adc_or_state[1]) hi_a++;
      if (adc_or_state[0]) hi_b++;
      tick();
    end
    n_cmp++; if (hi_a != 1024) begin n_err++; $display("FAIL or_a_len got %0d want 1024", hi_a); end
    n_cmp++; if (hi_b != 0) begin n_err++; $display("FAIL or_b_quiet got %0d want 0", hi_b); end
    hi_a = 0; hi_b = 0;
    adc_or_b = 1'b1;
    repeat (3) begin
      if (adc_or_state[0]) hi_b++;
      tick();
    end
    adc_or_b = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      if (adc_or_state[1]) hi_a++;
      if (adc_or_state[0]) hi_b++;
      tick();
    end
    n_cmp++; if (hi_b != 1026) begin n_err++; $display("FAIL or_b_len got %0d want 1026", hi_b); end
    n_cmp++; if (hi_a != 0) begin n_err++; $display("FAIL or_a_quiet got %0d want 0", hi_a); end
  endtask

  task automatic test_idelay();
    int hi, rises;
    logic prev;
    hi = 0; rises = 0; prev = idelay_rst;
    delay_rst = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (idelay_rst) hi++;
      if (idelay_rst && !prev) rises++;
      prev = idelay_rst;
    end
    n_cmp++; if (hi != 8) begin n_err++; $display("FAIL idelay_len got %0d want 8", hi); end
    n_cmp++; if (rises != 1) begin n_err++; $display("FAIL idelay_once got %0d want 1", rises); end
    delay_rst = 1'b0;
    repeat (5) tick();
    hi = 0;
    for (int c = 0; c < 40; c++) begin
      delay_rst = (c == 0 || c >= 3);
      tick();
      if (idelay_rst) hi++;
    end
    n_cmp++; if (hi != 11) begin n_err++; $display("FAIL idelay_restart got %0d want 11", hi); end
    delay_rst = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    int hi;
    got_data.delete(); got_last.delete();
    m_axis_tready = 1'b0;
    adc_data_a = 14'd5; adc_data_b = 14'd6;
    data_en = 1'b1;
    repeat (3) tick();
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL mr_pre_tvalid got %b want 1", m_axis_tvalid); end
    #2;
    areset = 1'b1;
    delay_rst = 1'b1;
    #1;
    n_cmp++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'd0 || m_axis_tlast !== 1'b0)
      begin n_err++; $display("FAIL mr_async got %b/%h/%b want 0/0/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
    data_en = 1'b0;
    repeat (2) tick();
    areset = 1'b0;
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (idelay_rst) hi++;
    end
    n_cmp++; if (hi != 8) begin n_err++; $display("FAIL mr_idelay got %0d want 8", hi); end
    delay_rst = 1'b0;
    got_data.delete(); got_last.delete();
    m_axis_tready = 1'b1;
    data_en = 1'b1;
    repeat (4) tick();
    data_en = 1'b0;
    repeat (15) tick();
    n_cmp++; if (got_data.size() != 4) begin n_err++; $display("FAIL mr_count got %0d want 4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      n_cmp++; if (got_data[i] !== mk(14'd5, 14'd6) || got_last[i] !== (i == 3))
        begin n_err++; $display("FAIL mr_word[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], mk(14'd5, 14'd6), (i == 3)); end
    end
  endtask

  initial begin
    areset = 1'b1;
    adc_data_a = '0; adc_data_b = '0;
    adc_or_a = 1'b0; adc_or_b = 1'b0;
    data_en = 1'b0; delay_rst = 1'b0;
    m_axis_tready = 1'b0;
    test_reset();
    test_capture();
    test_backpressure();
    test_full_pop();
    test_over_range();
    test_idelay();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_stream_capture.md
ADC_STREAM_CAPTURE -- requirements
Module: adc_stream_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14: ADC sample width per channel.
REQ-002 SHALL have parameter FRAME_LEN, default 1024: samples per AXI-Stream frame (2..65536).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: output FIFO entries (power of two).
REQ-004 SHALL have parameter OR_HOLD, default 1024: over-range stretch length, cycles.
REQ-005 SHALL have parameter DLY_RST_CYCLES, default 8: idelay_rst pulse length, cycles.
REQ-006 aclk  input  1  sole clock; all logic rising-edge.
REQ-007 areset  input  1  asynchronous, active-high reset.
REQ-008 adc_data_a / adc_data_b  input  DATA_WIDTH each  two's-complement samples, valid every cycle.
REQ-009 adc_or_a / adc_or_b  input  1 each  ADC over-range flags, per-sample.
REQ-010 data_en  input  1  capture enable level from register block.
REQ-011 delay_rst  input  1  IDELAY reset request level from register block.
REQ-012 adc_or_state  output  2  stretched over-range; [0]=channel B, [1]=channel A.
REQ-013 idelay_rst  output  1  IDELAY reset pulse.
REQ-014 overflow  output  1  sticky: sample dropped on full FIFO.
REQ-015 m_axis_tdata  output  32  {sext(b,16), sext(a,16)}.
REQ-016 m_axis_tvalid / m_axis_tlast  output  1 each; m_axis_tready  input  1.

Function
REQ-020 SHALL implement states IDLE, STREAM, DRAIN.
REQ-021 IDLE -> STREAM on cycle data_en sampled 1; frame counter cleared to 0.
REQ-022 In STREAM/DRAIN SHALL push one word per cycle (registered input, 1-cycle latency input-to-FIFO write).
REQ-023 Frame counter SHALL increment per sample cycle, wrap FRAME_LEN-1 -> 0; sample at count FRAME_LEN-1 carries tlast=1.
REQ-024 STREAM -> DRAIN when data_en sampled 0; DRAIN continues until tlast sample pushed, then IDLE; frames never truncated.
REQ-025 DRAIN with data_en returning 1 SHALL return to STREAM without gap or counter reset.
REQ-026 FIFO full at push: word dropped, counter still advances (frame timing preserved), overflow set; cleared only by reset or data_en rising edge.
REQ-027 FIFO SHALL support simultaneous push and pop when full (pop frees slot same cycle; no drop).
REQ-028 m_axis SHALL obey AXI-Stream: tdata/tlast stable while tvalid=1 and tready=0; tvalid never deasserts without handshake.
REQ-029 FIFO drains to empty in IDLE; tvalid=0 when empty.
REQ-030 Per channel, or-input high SHALL reload a counter with OR_HOLD; adc_or_state bit = counter nonzero; counter decrements to 0 otherwise; independent of data_en.
REQ-031 Rising edge of delay_rst SHALL assert idelay_rst for exactly DLY_RST_CYCLES cycles, starting next cycle; further edges during pulse restart the count.
REQ-032 Sign extension: bit DATA_WIDTH-1 replicated into bits 15..DATA_WIDTH of each half.

Reset
REQ-040 areset SHALL asynchronously force: state IDLE, counters 0, FIFO empty, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, adc_or_state=0, idelay_rst=0, overflow=0.
REQ-041 Reset mid-frame SHALL discard partial frame; after release, a new frame starts at count 0 on next data_en=1.
REQ-042 Edge detectors SHALL reset their history to 0 (delay_rst held 1 through reset release produces one pulse).

Verification
V-1 FRAME_LEN=4, tready=1, data_en 1 for 6 cycles, a=0x1FFF,b=0x2000 -> 8 words, tlast on words 4 and 8, tdata=0xE0001FFF.
V-2 tready=0, data_en=1 for 20 cycles, FIFO_DEPTH=16 -> 16 words held, overflow=1; tready=1 -> 16 words out unchanged, tvalid then 0.
V-3 adc_or_a pulse 1 cycle, OR_HOLD=1024 -> adc_or_state[1]=1 for 1024 cycles, [0] stays 0.
V-4 delay_rst 0->1 held 100 cycles -> idelay_rst high exactly 8 cycles, once.
V-5 areset asserted at sample 2 of frame, tvalid=1 -> outputs zero immediately (asynchronous); next capture tlast after FRAME_LEN samples.
V-6 FIFO full with tready=1 each cycle under continuous capture -> no drop, overflow stays 0.
